// File: rtl/bdc_pkg.sv
// Shared constants and types for the motor-controller SPI register front end.
package bdc_pkg;

   // Command byte field positions
   localparam int RW_BIT     = 7;
   localparam int ADDR_MSB   = 6;
   localparam int ADDR_LSB   = 3;

   // SCLK rising edges per transaction: command byte + data byte
   localparam int FRAME_BITS = 16;

   // Register-file address map
   localparam logic [3:0] PWM0  = 4'h0;
   localparam logic [3:0] CFG   = 4'h2;
   localparam logic [3:0] PWM1  = 4'h4;
   localparam logic [3:0] PWM2  = 4'h8;
   localparam logic [3:0] HWCFG = 4'hd;
   localparam logic [3:0] WDDIV = 4'he;
   localparam logic [3:0] WDCTL = 4'hf;

   // Deframer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

endpackage

// File: rtl/spi_regif_if.sv
// Register-file port between the SPI deframer (master) and the register file (slave).
interface spi_regif_if;

   logic [3:0] regaddr;
   logic [7:0] wrdata;
   logic       wrstb;
   logic       rdstb;
   logic [7:0] rddata;

   modport master (
      output regaddr,
      output wrdata,
      output wrstb,
      output rdstb,
      input  rddata
   );

   modport slave (
      input  regaddr,
      input  wrdata,
      input  wrstb,
      input  rdstb,
      output rddata
   );

endinterface

// File: rtl/spi_sync.sv
// Pin synchronizer with edge pulses. Edges are suppressed until the whole
// chain plus the edge register hold real pin samples, so a pin that is
// already high when reset releases does not look like a rising edge.
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;
   logic [STAGES:0]   primed;

   // Synchronizer chain, edge register and post-reset priming shifter
   // NOTE: non-blocking (<=) so every flop samples the pre-edge value of its
   // neighbour; blocking here would collapse the chain into a single flop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync   <= '0;
         prev   <= 1'b0;
         primed <= '0;
      end else begin
         sync[0] <= pin;
         for (int i = 1; i < STAGES; i++) begin
            sync[i] <= sync[i-1];
         end
         prev   <= sync[STAGES-1];
         primed <= {primed[STAGES-1:0], 1'b1};
      end
   end

   assign level = sync[STAGES-1];
   assign rise  = primed[STAGES] &  level & ~prev;
   assign fall  = primed[STAGES] & ~level &  prev;

endmodule

// File: rtl/spi_regif.sv
// SPI slave front end: deframes 16-bit command+data transactions from the
// oversampled SPI pins and drives the register-file port; returns read data
// on miso during the data byte.
module spi_regif
   import bdc_pkg::*;
#(
   parameter int FRAME_BITS  = bdc_pkg::FRAME_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             sclk,
   input  logic             ss,
   input  logic             mosi,
   output logic             miso,
   output logic             misooe,
   output logic             frmerr,
   spi_regif_if.master      bus
);

   localparam int CNT_W = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(FRAME_BITS/2 - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic ss_rise, ss_fall, ss_level_unused;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk    (clk),
      .resetn (resetn),
      .pin    (sclk),
      .level  (sclk_level_unused),
      .rise   (sclk_rise),
      .fall   (sclk_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
      .clk    (clk),
      .resetn (resetn),
      .pin    (ss),
      .level  (ss_level_unused),
      .rise   (ss_rise),
      .fall   (ss_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk    (clk),
      .resetn (resetn),
      .pin    (mosi),
      .level  (mosi_level),
      .rise   (mosi_rise_unused),
      .fall   (mosi_fall_unused)
   );

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       rx_sh;
   logic [7:0]       tx_sh;
   logic             rd_flag;
   logic [3:0]       regaddr;
   logic [7:0]       wrdata;
   logic             wrstb;
   logic             rdstb;
   logic [7:0]       rx_next;

   // Shifter contents after taking in the current mosi bit, LSB in
   assign rx_next = {rx_sh[6:0], mosi_level};

   // Deframer FSM: bit counter, shifters, register-port strobes and miso
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         rx_sh   <= '0;
         tx_sh   <= '0;
         rd_flag <= 1'b0;
         regaddr <= '0;
         wrdata  <= '0;
         wrstb   <= 1'b0;
         rdstb   <= 1'b0;
         frmerr  <= 1'b0;
         miso    <= 1'b0;
         misooe  <= 1'b0;
      end else begin
         wrstb  <= 1'b0;
         rdstb  <= 1'b0;
         frmerr <= 1'b0;
         if (ss_fall) begin
            // A nonzero count means the master quit mid-frame
            frmerr <= (cnt != '0);
            state  <= IDLE;
            cnt    <= '0;
            rx_sh  <= '0;
            miso   <= 1'b0;
            misooe <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_rise) state <= CMD;
               end
               CMD, DATA: begin
                  if (sclk_rise) begin
                     rx_sh <= rx_next;
                     if (cnt == FRAME_LAST) begin
                        cnt    <= '0;
                        state  <= CMD;
                        miso   <= 1'b0;
                        misooe <= 1'b0;
                        if (!rd_flag) begin
                           wrdata <= rx_next;
                           wrstb  <= 1'b1;
                        end
                     end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CMD_LAST) begin
                           state   <= DATA;
                           regaddr <= rx_next[ADDR_MSB:ADDR_LSB];
                           rd_flag <= rx_next[RW_BIT];
                           rdstb   <= rx_next[RW_BIT];
                        end
                     end
                  end else if (sclk_fall && state == DATA && rd_flag) begin
                     miso   <= tx_sh[7];
                     tx_sh  <= {tx_sh[6:0], 1'b0};
                     misooe <= 1'b1;
                  end else if (rdstb) begin
                     // Register file answers the cycle after the strobe
                     tx_sh <= bus.rddata;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.regaddr = regaddr;
   assign bus.wrdata  = wrdata;
   assign bus.wrstb   = wrstb;
   assign bus.rdstb   = rdstb;

endmodule
